// File: rtl/spi_master_arbiter.sv
// ----------------------------------------------------------------------------
// spi_master_arbiter : round-robin, burst-locking share of one SPI master engine
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ-1:0]         req_last_i,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  output logic [NUM_REQ-1:0]         rsp_valid_o,
  output logic [DATA_W-1:0]          rsp_data_o,
  output logic                       rsp_err_o,
  output logic                       eng_start_o,
  output logic [DATA_W-1:0]          eng_data_o,
  output logic                       eng_abort_o,
  input  logic                       eng_done_i,
  input  logic [DATA_W-1:0]          eng_rdata_i,
  output logic [NUM_REQ-1:0]         eng_csn_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_o
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_HOLD  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_grant_q, last_grant_d;
  logic                last_q, last_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;

  logic [GW-1:0]       pick;
  logic [GW-1:0]       cand;
  logic                found;

  // Round-robin scan starting just after the previous owner.
  always_comb begin
    pick  = last_grant_q;
    cand  = last_grant_q;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    last_d       = last_q;
    timer_d      = '0;
    rsp_valid_d  = '0;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    eng_start_o  = 1'b0;
    eng_abort_o  = 1'b0;
    req_ready_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = S_START;
        end
      end
      S_START: begin
        eng_start_o          = 1'b1;
        req_ready_o[grant_q] = 1'b1;
        last_d               = req_last_i[grant_q];
        state_d              = S_BUSY;
      end
      S_BUSY: begin
        // A done arriving on the final timeout cycle still counts as success.
        if (eng_done_i) begin
          rsp_valid_d[grant_q] = 1'b1;
          rsp_data_d           = eng_rdata_i;
          rsp_err_d            = 1'b0;
          if (last_q) begin
            state_d      = S_IDLE;
            last_grant_d = grant_q;
          end else begin
            state_d = S_HOLD;
          end
        end else if (timer_q == TMAX) begin
          eng_abort_o          = 1'b1;
          rsp_valid_d[grant_q] = 1'b1;
          rsp_err_d            = 1'b1;
          rsp_data_d           = '0;
          state_d              = S_IDLE;
          last_grant_d         = grant_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (req_valid_i[grant_q]) begin
          state_d = S_START;
        end else if (timer_q == TMAX) begin
          state_d      = S_IDLE;
          last_grant_d = grant_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NUM_REQ - 1);
      last_q       <= 1'b0;
      timer_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      last_q       <= last_d;
      timer_q      <= timer_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  // Owner's chip select is low from START through BUSY/HOLD.
  always_comb begin
    eng_csn_o = '1;
    if (state_q != S_IDLE) eng_csn_o[grant_q] = 1'b0;
  end

  assign eng_data_o  = req_data_i[int'(grant_q)*DATA_W +: DATA_W];
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign grant_o     = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
// ----------------------------------------------------------------------------
// tb_spi_master_arbiter : directed bench for spi_master_arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_master_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_last, req_ready, rsp_valid, eng_csn;
  logic [N*W-1:0] req_data;
  logic [W-1:0]   rsp_data, eng_data, eng_rdata;
  logic           rsp_err, eng_start, eng_abort, eng_done;
  logic [1:0]     grant;

  int checks = 0;
  int errors = 0;

  spi_master_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .eng_start_o(eng_start), .eng_data_o(eng_data),
    .eng_abort_o(eng_abort), .eng_done_i(eng_done), .eng_rdata_i(eng_rdata),
    .eng_csn_o(eng_csn), .grant_o(grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the START cycle; engine answers 5 cycles after start.
  task automatic word(input int g, input logic [31:0] rd, input bit idle_after);
    logic [3:0] oh;
    oh = 4'b0001 << g;
    chk("start", {eng_start, req_ready, eng_csn, grant}, {1'b1, oh, ~oh, 2'(g)});
    chk("txdata", eng_data, 32'hA000_0000 | g);
    repeat (4) begin
      tick();
      chk("busy", {eng_start, req_ready, eng_csn, rsp_valid, eng_abort},
          {1'b0, 4'b0000, ~oh, 4'b0000, 1'b0});
    end
    tick();
    eng_done  = 1'b1;
    eng_rdata = rd;
    tick();
    eng_done = 1'b0;
    chk("rsp", {rsp_valid, rsp_err, eng_csn}, {oh, 1'b0, idle_after ? 4'hF : ~oh});
    chk("rdata", rsp_data, rd);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_last  = '0;
    eng_done  = 1'b0;
    eng_rdata = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 32'hA000_0000 | i;

    // Reset and idle, including a stray done that must be ignored
    repeat (3) tick();
    rst = 1'b0;
    chk("reset", {eng_csn, eng_start, eng_abort, req_ready, rsp_valid, rsp_err, grant},
        {4'hF, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0});
    chk("reset_rdata", rsp_data, 32'h0);
    for (int i = 0; i < 20; i++) begin
      eng_done = (i == 5);
      tick();
      chk("idle", {eng_csn, eng_start, eng_abort, req_ready, rsp_valid},
          {4'hF, 1'b0, 1'b0, 4'h0, 4'h0});
    end
    eng_done = 1'b0;

    // All four requesting single-word bursts: 0,1,2,3,0
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    tick(); word(0, 32'h1000, 1'b1);
    tick(); word(1, 32'h1001, 1'b1);
    tick(); word(2, 32'h1002, 1'b1);
    tick(); word(3, 32'h1003, 1'b1);
    tick(); word(0, 32'h1004, 1'b1);

    // Requester 2 three-word burst while requester 0 waits
    req_valid = 4'b0101;
    req_last  = 4'b0001;
    tick(); word(2, 32'h2000, 1'b0);
    tick(); word(2, 32'h2001, 1'b0);
    req_last = 4'b0101;
    tick(); word(2, 32'h2002, 1'b1);
    tick(); word(0, 32'h2003, 1'b1);
    req_valid = '0;
    req_last  = '0;

    // Engine never answers: abort on 16th cycle after start
    req_valid = 4'b0010;
    req_last  = 4'b0010;
    tick();
    chk("to_start", {eng_start, req_ready, grant}, {1'b1, 4'b0010, 2'd1});
    req_valid = '0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_wait", {eng_abort, eng_csn, rsp_valid}, {1'b0, 4'b1101, 4'b0000});
    end
    tick();
    chk("to_abort", {eng_abort, rsp_valid, eng_csn}, {1'b1, 4'b0000, 4'b1101});
    tick();
    chk("to_rsp", {eng_abort, rsp_valid, rsp_err, eng_csn}, {1'b0, 4'b0010, 1'b1, 4'hF});
    chk("to_rdata", rsp_data, 32'h0);

    // Done on the timeout cycle wins
    req_valid = 4'b0100;
    req_last  = 4'b0100;
    tick();
    chk("co_start", {eng_start, req_ready, grant}, {1'b1, 4'b0100, 2'd2});
    req_valid = '0;
    repeat (15) tick();
    tick();
    eng_done  = 1'b1;
    eng_rdata = 32'hDEADBEEF;
    #1;
    chk("co_noabort", eng_abort, 1'b0);
    tick();
    eng_done = 1'b0;
    chk("co_rsp", {eng_abort, rsp_valid, rsp_err, eng_csn}, {1'b0, 4'b0100, 1'b0, 4'hF});
    chk("co_rdata", rsp_data, 32'hDEADBEEF);

    // Reset while BUSY: silent release, requester 0 wins afterwards
    req_valid = 4'b1000;
    req_last  = 4'b1000;
    tick();
    chk("rb_start", {eng_start, grant, eng_csn}, {1'b1, 2'd3, 4'b0111});
    req_valid = '0;
    tick();
    chk("rb_busy", eng_csn, 4'b0111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rb_reset", {eng_csn, rsp_valid, eng_abort, grant}, {4'hF, 4'h0, 1'b0, 2'd0});
    req_valid = 4'b1001;
    req_last  = 4'b1001;
    tick();
    chk("rb_prio", {eng_start, req_ready, eng_csn, grant}, {1'b1, 4'b0001, 4'b1110, 2'd0});
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
